// File: rtl/alu_pkg.sv
// alu_pkg: FS opcodes, FSM states and op classification shared by mips_alu_md
package alu_pkg;
  localparam logic [4:0] FS_PASS_S  = 5'h00;
  localparam logic [4:0] FS_PASS_T  = 5'h01;
  localparam logic [4:0] FS_ADD     = 5'h02;
  localparam logic [4:0] FS_SUB     = 5'h03;
  localparam logic [4:0] FS_ADDU    = 5'h04;
  localparam logic [4:0] FS_SUBU    = 5'h05;
  localparam logic [4:0] FS_SLT     = 5'h06;
  localparam logic [4:0] FS_SLTU    = 5'h07;
  localparam logic [4:0] FS_AND     = 5'h08;
  localparam logic [4:0] FS_OR      = 5'h09;
  localparam logic [4:0] FS_XOR     = 5'h0A;
  localparam logic [4:0] FS_NOR     = 5'h0B;
  localparam logic [4:0] FS_INC     = 5'h0F;
  localparam logic [4:0] FS_DEC     = 5'h10;
  localparam logic [4:0] FS_INC4    = 5'h11;
  localparam logic [4:0] FS_DEC4    = 5'h12;
  localparam logic [4:0] FS_ZEROS   = 5'h13;
  localparam logic [4:0] FS_ONES    = 5'h14;
  localparam logic [4:0] FS_SP_INIT = 5'h15;
  localparam logic [4:0] FS_ANDI    = 5'h16;
  localparam logic [4:0] FS_ORI     = 5'h17;
  localparam logic [4:0] FS_LUI     = 5'h18;
  localparam logic [4:0] FS_XORI    = 5'h19;
  localparam logic [4:0] FS_MULT    = 5'h1A;
  localparam logic [4:0] FS_MULTU   = 5'h1B;
  localparam logic [4:0] FS_DIV     = 5'h1C;
  localparam logic [4:0] FS_DIVU    = 5'h1D;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  function automatic logic is_multicycle(input logic [4:0] fs);
    return fs >= FS_MULT && fs <= FS_DIVU;
  endfunction
endpackage

// File: rtl/mips_alu_md_if.sv
// mips_alu_md_if: ALU request/result bus; master drives start/fs/s/t, slave returns busy/done/y_hi/y_lo/n/z/v/c
interface mips_alu_md_if #(parameter int WIDTH = 32);
  logic start, busy, done, n, z, v, c;
  logic [4:0] fs;
  logic [WIDTH-1:0] s, t, y_hi, y_lo;
  modport master(output start, fs, s, t, input busy, done, y_hi, y_lo, n, z, v, c);
  modport slave(input start, fs, s, t, output busy, done, y_hi, y_lo, n, z, v, c);
endinterface

// File: rtl/alu_muldiv_core.sv
// alu_muldiv_core: unsigned iterative engine, shift-add multiply (mode 0) or restoring divide (mode 1), one bit per cycle
//   go loads a/b/mode; fin is high in the cycle whose closing edge performs the last step; {hi,lo} is product or {rem,quot}
module alu_muldiv_core #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0] cnt;
  logic mode_r;
  logic [WIDTH:0] sum, sh, diff;
  // sh is the partial remainder shifted left with the next dividend bit brought in
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_r} : '0);
    sh = p[2*WIDTH-1:WIDTH-1];
    diff = sh - {1'b0, b_r};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      p <= '0;
      b_r <= '0;
      cnt <= '0;
      mode_r <= 1'b0;
    end else if (go) begin
      p <= {{WIDTH{1'b0}}, a};
      b_r <= b;
      cnt <= CW'(WIDTH);
      mode_r <= mode;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      p <= !mode_r ? {sum, p[WIDTH-1:1]} :
           diff[WIDTH] ? {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end
  assign fin = cnt == CW'(1);
  assign hi = p[2*WIDTH-1:WIDTH];
  assign lo = p[WIDTH-1:0];
endmodule

// File: rtl/mips_alu_md.sv
// mips_alu_md: registered execute-stage ALU; single-cycle FS ops plus optional iterative mul/div (macro ALU_MULDIV_EN)
//   ports: clk, reset_n (async active-low), bus (mips_alu_md_if.slave: start/fs/s/t in; busy/done/y_hi/y_lo/n/z/v/c out)
module mips_alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] SP_INIT_VAL = 'h3FC
) (
  input logic clk,
  input logic reset_n,
  mips_alu_md_if.slave bus
);
  logic [WIDTH-1:0] s, t, b_op, sc_y, y_hi, y_lo;
  logic [WIDTH:0] add_r, sub_r;
  logic sc_n, sc_v, sc_c, done, n, z, v, c;
  assign s = bus.s;
  assign t = bus.t;
  // INC/DEC variants reuse the add/sub paths with a constant second operand
  always_comb begin
    b_op = (bus.fs == FS_INC || bus.fs == FS_DEC) ? WIDTH'(1) :
           (bus.fs == FS_INC4 || bus.fs == FS_DEC4) ? WIDTH'(4) : t;
    add_r = {1'b0, s} + {1'b0, b_op};
    sub_r = {1'b0, s} - {1'b0, b_op};
    sc_y = s;
    sc_v = 1'b0;
    sc_c = 1'b0;
    case (bus.fs)
      FS_PASS_T: sc_y = t;
      FS_ADD, FS_INC, FS_INC4: begin
        sc_y = add_r[WIDTH-1:0];
        sc_c = add_r[WIDTH];
        sc_v = (s[WIDTH-1] == b_op[WIDTH-1]) && (add_r[WIDTH-1] != s[WIDTH-1]);
      end
      FS_SUB, FS_DEC, FS_DEC4: begin
        sc_y = sub_r[WIDTH-1:0];
        sc_c = sub_r[WIDTH];
        sc_v = (s[WIDTH-1] != b_op[WIDTH-1]) && (sub_r[WIDTH-1] != s[WIDTH-1]);
      end
      FS_ADDU: {sc_y, sc_c, sc_v} = {add_r[WIDTH-1:0], add_r[WIDTH], add_r[WIDTH]};
      FS_SUBU: {sc_y, sc_c, sc_v} = {sub_r[WIDTH-1:0], sub_r[WIDTH], sub_r[WIDTH]};
      FS_SLT: sc_y = WIDTH'($signed(s) < $signed(t));
      FS_SLTU: sc_y = WIDTH'(s < t);
      FS_AND: sc_y = s & t;
      FS_OR: sc_y = s | t;
      FS_XOR: sc_y = s ^ t;
      FS_NOR: sc_y = ~(s | t);
      FS_ZEROS: sc_y = '0;
      FS_ONES: sc_y = '1;
      FS_SP_INIT: sc_y = SP_INIT_VAL;
      FS_ANDI: sc_y = s & WIDTH'(t[15:0]);
      FS_ORI: sc_y = s | WIDTH'(t[15:0]);
      FS_XORI: sc_y = s ^ WIDTH'(t[15:0]);
      FS_LUI: sc_y = WIDTH'(t[15:0]) << (WIDTH - 16);
      // only reached when the mul/div datapath is absent: zero result flagged as unsupported
      FS_MULT, FS_MULTU, FS_DIV, FS_DIVU: {sc_y, sc_v} = {{WIDTH{1'b0}}, 1'b1};
      default: sc_y = s;
    endcase
    sc_n = sc_y[WIDTH-1] & ~(bus.fs == FS_ADDU || bus.fs == FS_SUBU || bus.fs == FS_SLTU);
  end
`ifdef ALU_MULDIV_EN
  state_t st;
  logic busy, go, fin, sgn, md_div, md_sgn, md_v, dz, t_neg, neg_q, neg_r;
  logic [WIDTH-1:0] s_r, s_mag, t_mag, hi, lo, md_hi, md_lo;
  logic [2*WIDTH-1:0] p_fix;
  // within mul/div, fs[0]=0 selects the signed flavour and fs[2]=1 selects divide
  assign sgn = ~bus.fs[0];
  assign go = bus.start && st == IDLE && is_multicycle(bus.fs);
  assign s_mag = (sgn && s[WIDTH-1]) ? -s : s;
  assign t_mag = (sgn && t[WIDTH-1]) ? -t : t;
  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk), .reset_n(reset_n), .go(go), .mode(bus.fs[2]),
    .a(s_mag), .b(t_mag), .fin(fin), .hi(hi), .lo(lo)
  );
  // quotient/product sign from both operands, remainder sign follows the dividend
  assign neg_q = md_sgn & (s_r[WIDTH-1] ^ t_neg);
  assign neg_r = md_sgn & s_r[WIDTH-1];
  assign p_fix = neg_q ? -{hi, lo} : {hi, lo};
  assign md_lo = !md_div ? p_fix[WIDTH-1:0] : dz ? '1 : neg_q ? -lo : lo;
  assign md_hi = !md_div ? p_fix[2*WIDTH-1:WIDTH] : dz ? s_r : neg_r ? -hi : hi;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      {busy, done, n, z, v, c} <= '0;
      {y_hi, y_lo, s_r} <= '0;
      {md_div, md_sgn, md_v, dz, t_neg} <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE:
          if (go) begin
            st <= CALC;
            busy <= 1'b1;
            md_div <= bus.fs[2];
            md_sgn <= sgn;
            s_r <= s;
            t_neg <= t[WIDTH-1];
            dz <= bus.fs[2] && t == '0;
            md_v <= bus.fs[2] && (t == '0 || (sgn && s == {1'b1, {(WIDTH-1){1'b0}}} && &t));
          end else if (bus.start) begin
            done <= 1'b1;
            y_hi <= '0;
            y_lo <= sc_y;
            {n, z, v, c} <= {sc_n, sc_y == '0, sc_v, sc_c};
          end
        CALC: if (fin) st <= FIX;
        FIX: begin
          st <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          y_hi <= md_hi;
          y_lo <= md_lo;
          {n, z, v, c} <= {md_hi[WIDTH-1], {md_hi, md_lo} == '0, md_v, 1'b0};
        end
        default: st <= IDLE;
      endcase
    end
  assign bus.busy = busy;
`else
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {done, n, z, v, c} <= '0;
      {y_hi, y_lo} <= '0;
    end else begin
      done <= bus.start;
      if (bus.start) {y_hi, y_lo, n, z, v, c} <= {{WIDTH{1'b0}}, sc_y, sc_n, sc_y == '0, sc_v, sc_c};
    end
  assign bus.busy = 1'b0;
`endif
  assign bus.done = done;
  assign bus.y_hi = y_hi;
  assign bus.y_lo = y_lo;
  assign {bus.n, bus.z, bus.v, bus.c} = {n, z, v, c};
endmodule

// File: tb/tb_mips_alu_md.sv
// tb_mips_alu_md: directed vector bench for mips_alu_md at WIDTH=32 and WIDTH=16
module tb_mips_alu_md;
  import alu_pkg::*;
  typedef struct {
    logic [4:0] fs;
    logic [31:0] s, t, hi, lo;
    logic [3:0] f;
    int lat;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0;
  int total = 0, passed = 0, cyc, idle;
  vec_t vq[$];
  logic [69:0] o32;
  logic [37:0] o16;
  mips_alu_md_if #(.WIDTH(32)) b32();
  mips_alu_md_if #(.WIDTH(16)) b16();
  mips_alu_md #(.WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(b32));
  mips_alu_md #(.WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(b16));
  always #5 clk = ~clk;
  assign o32 = {b32.done, b32.busy, b32.y_hi, b32.y_lo, b32.n, b32.z, b32.v, b32.c};
  assign o16 = {b16.done, b16.busy, b16.y_hi, b16.y_lo, b16.n, b16.z, b16.v, b16.c};
`ifndef ALU_MULDIV_EN
  int busy_seen = 0;
  always @(negedge clk) if (b32.busy || b16.busy) busy_seen++;
`endif
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic addv(input logic [4:0] fs, input logic [31:0] s, t, hi, lo, input logic [3:0] f, input int lat);
    vq.push_back('{fs, s, t, hi, lo, f, lat});
  endtask
  task automatic run32(input vec_t vv, input int idx);
    @(negedge clk);
    b32.start = 1'b1; b32.fs = vv.fs; b32.s = vv.s; b32.t = vv.t;
    @(negedge clk);
    b32.start = 1'b0;
    cyc = 0; idle = 0;
    while (!b32.done && cyc < 200) begin
      if (!b32.busy) idle++;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d fs=%0h latency/busy", idx, vv.fs), {cyc, idle}, {vv.lat, 32'd0});
    chk($sformatf("v%0d fs=%0h result", idx, vv.fs), o32, {2'b10, vv.hi, vv.lo, vv.f});
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    b32.start = 1'b0; b32.fs = '0; b32.s = '0; b32.t = '0;
    b16.start = 1'b0; b16.fs = '0; b16.s = '0; b16.t = '0;
    repeat (2) @(negedge clk);
    chk("reset state 32", o32, '0);
    chk("reset state 16", o16, '0);
    reset_n = 1'b1;
    // flags nzvc; lat = cycles from the sampling edge to done seen
    addv(FS_ADD,     32'h7FFF_FFFF, 32'h1,         0, 32'h8000_0000, 4'b1010, 0);
    addv(FS_SUB,     32'h0,         32'h1,         0, 32'hFFFF_FFFF, 4'b1001, 0);
    addv(FS_SUBU,    32'h0,         32'h1,         0, 32'hFFFF_FFFF, 4'b0011, 0);
    addv(FS_ADDU,    32'hFFFF_FFFF, 32'h1,         0, 32'h0,         4'b0111, 0);
    addv(FS_ADD,     32'hFFFF_FFFF, 32'h1,         0, 32'h0,         4'b0101, 0);
    addv(FS_ADDU,    32'h7FFF_FFFF, 32'h1,         0, 32'h8000_0000, 4'b0000, 0);
    addv(FS_SUB,     32'h8000_0000, 32'h1,         0, 32'h7FFF_FFFF, 4'b0010, 0);
    addv(FS_SUBU,    32'h5,         32'h3,         0, 32'h2,         4'b0000, 0);
    addv(FS_SLT,     32'hFFFF_FFFF, 32'h1,         0, 32'h1,         4'b0000, 0);
    addv(FS_SLTU,    32'hFFFF_FFFF, 32'h1,         0, 32'h0,         4'b0100, 0);
    addv(FS_AND,     32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hF000_F000, 4'b1000, 0);
    addv(FS_OR,      32'h0F0F_0000, 32'h0000_00F0, 0, 32'h0F0F_00F0, 4'b0000, 0);
    addv(FS_XOR,     32'hAAAA_5555, 32'hFFFF_0000, 0, 32'h5555_5555, 4'b0000, 0);
    addv(FS_NOR,     32'h0,         32'h0,         0, 32'hFFFF_FFFF, 4'b1000, 0);
    addv(FS_INC,     32'h7FFF_FFFF, 32'h1234,      0, 32'h8000_0000, 4'b1010, 0);
    addv(FS_DEC,     32'h0,         32'h1234,      0, 32'hFFFF_FFFF, 4'b1001, 0);
    addv(FS_INC4,    32'hFFFF_FFFE, 32'h0,         0, 32'h2,         4'b0001, 0);
    addv(FS_DEC4,    32'h8000_0000, 32'h0,         0, 32'h7FFF_FFFC, 4'b0010, 0);
    addv(FS_ZEROS,   32'h1234,      32'h5678,      0, 32'h0,         4'b0100, 0);
    addv(FS_ONES,    32'h0,         32'h0,         0, 32'hFFFF_FFFF, 4'b1000, 0);
    addv(FS_SP_INIT, 32'h0,         32'h0,         0, 32'h3FC,       4'b0000, 0);
    addv(FS_ANDI,    32'hFFFF_1234, 32'hABCD_00FF, 0, 32'h34,        4'b0000, 0);
    addv(FS_ORI,     32'h1234_0000, 32'hFFFF_5678, 0, 32'h1234_5678, 4'b0000, 0);
    addv(FS_LUI,     32'h0,         32'h0000_ABCD, 0, 32'hABCD_0000, 4'b1000, 0);
    addv(FS_XORI,    32'h0000_FFFF, 32'h1234_5555, 0, 32'h0000_AAAA, 4'b0000, 0);
    addv(FS_PASS_S,  32'hDEAD_BEEF, 32'h1,         0, 32'hDEAD_BEEF, 4'b1000, 0);
    addv(FS_PASS_T,  32'hFFFF_FFFF, 32'h5,         0, 32'h5,         4'b0000, 0);
    addv(5'h0C,      32'h8000_0001, 32'h7,         0, 32'h8000_0001, 4'b1000, 0);
    addv(5'h1F,      32'h0,         32'hFFFF_FFFF, 0, 32'h0,         4'b0100, 0);
`ifdef ALU_MULDIV_EN
    addv(FS_MULT,  32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 4'b1000, 33);
    addv(FS_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 4'b1000, 33);
    addv(FS_MULT,  32'h0,         32'h5,         32'h0,         32'h0,         4'b0100, 33);
    addv(FS_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0,         4'b0000, 33);
    addv(FS_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b1000, 33);
    addv(FS_DIV,   32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 4'b0000, 33);
    addv(FS_DIVU,  32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 4'b0000, 33);
    addv(FS_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 4'b0010, 33);
    addv(FS_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 4'b1010, 33);
    addv(FS_DIVU,  32'h7,         32'h0,         32'h7,         32'hFFFF_FFFF, 4'b0010, 33);
`else
    addv(FS_MULT,  32'hFFFF_FFFE, 32'h3,         0, 32'h0, 4'b0110, 0);
    addv(FS_DIVU,  32'h7,         32'h0,         0, 32'h0, 4'b0110, 0);
`endif
    foreach (vq[i]) run32(vq[i], i);
    // single-cycle starts accepted on consecutive edges
    @(negedge clk);
    b32.start = 1'b1; b32.fs = FS_ADD; b32.s = 32'h1; b32.t = 32'h2;
    @(negedge clk);
    chk("back-to-back first", o32, {2'b10, 32'h0, 32'h3, 4'b0000});
    b32.fs = FS_OR; b32.s = 32'h5; b32.t = 32'h8;
    @(negedge clk);
    chk("back-to-back second", o32, {2'b10, 32'h0, 32'hD, 4'b0000});
    b32.start = 1'b0;
    @(negedge clk);
    chk("hold after done", o32, {2'b00, 32'h0, 32'hD, 4'b0000});
`ifdef ALU_MULDIV_EN
    // MULT with a stray start while busy
    @(negedge clk);
    b32.start = 1'b1; b32.fs = FS_MULT; b32.s = 32'hFFFF_FFFE; b32.t = 32'h3;
    @(negedge clk);
    b32.fs = FS_ADD; b32.s = 32'h1; b32.t = 32'h1;
    cyc = 0; idle = 0;
    while (!b32.done && cyc < 200) begin
      if (!b32.busy) idle++;
      b32.start = (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    b32.start = 1'b0;
    chk("mult ignored-start latency/busy", {cyc, idle}, {32'd33, 32'd0});
    chk("mult ignored-start result", o32, {2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 4'b1000});
    @(negedge clk);
    chk("no done from ignored start", b32.done, 1'b0);
`endif
    // reset asserted ten cycles into a MULTU
    @(negedge clk);
    b32.start = 1'b1; b32.fs = FS_MULTU; b32.s = 32'hFFFF_FFFF; b32.t = 32'hFFFF_FFFF;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async reset mid-op", o32, '0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.done) cyc++;
    end
    chk("no done after reset", cyc, 0);
    vq.delete();
    addv(FS_ANDI, 32'hFFFF_1234, 32'h0000_00FF, 0, 32'h34, 4'b0000, 0);
    run32(vq[0], 99);
    // 16-bit instance
    @(negedge clk);
    b16.start = 1'b1; b16.fs = FS_LUI; b16.s = 16'h1234; b16.t = 16'h00AB;
    @(negedge clk);
    b16.start = 1'b0;
    chk("w16 LUI", o16, {2'b10, 16'h0, 16'h00AB, 4'b0000});
    @(negedge clk);
    b16.start = 1'b1; b16.fs = FS_MULT; b16.s = 16'hFFFE; b16.t = 16'h3;
    @(negedge clk);
    b16.start = 1'b0;
    cyc = 0;
    while (!b16.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
`ifdef ALU_MULDIV_EN
    chk("w16 MULT latency", cyc, 17);
    chk("w16 MULT result", o16, {2'b10, 16'hFFFF, 16'hFFFA, 4'b1000});
`else
    chk("w16 MULT latency", cyc, 0);
    chk("w16 MULT unsupported", o16, {2'b10, 16'h0, 16'h0, 4'b0110});
    chk("busy never asserted", busy_seen, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mips_alu_md.md
# mips_alu_md

Parametrised, registered successor to the processor's combinational 32-bit ALU. Executes the same 5-bit FS operation set at configurable width. Adds iterative signed/unsigned multiply and divide that drive a real HI/LO pair (`y_hi`/`y_lo`) through a start/done handshake. Sits in the execute stage; the control unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand/result width; even, ≥16.
- `SP_INIT_VAL`, 'h3FC: value produced by FS 0x15.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch operation; sampled only in IDLE.
- `fs` in 5: function select, latched on start.
- `s`, `t` in WIDTH: operands, latched on start.
- `busy` out 1: high from the edge after start until done; reset 0.
- `done` out 1: one-cycle pulse, results valid; reset 0.
- `y_hi`, `y_lo` out WIDTH: results; reset 0.
- `n`, `z`, `v`, `c` out 1: flags; reset 0.

## Operation
- FS 0x00–0x0B, 0x0F–0x19: same functions as the existing ALU (PASS_S, PASS_T, ADD, SUB, ADDU, SUBU, SLT, SLTU, AND, OR, XOR, NOR, INC, DEC, INC4, DEC4, ZEROS, ONES, SP_INIT, ANDI, ORI, LUI, XORI). y_hi = 0 for all of these.
- Immediates zero-extend `t[15:0]`. LUI = `t[15:0]` << (WIDTH-16).
- Flags, single-cycle ops:
  - N = y_lo MSB (forced 0 for ADDU, SUBU, SLTU); Z = (y_lo == 0).
  - ADD/INC/INC4: C = carry-out; V = signed overflow of the actual operands.
  - SUB/DEC/DEC4/SUBU: C = unsigned borrow; V = signed overflow (SUBU, ADDU: V = C).
  - Logic, compare, constant and pass ops: V = C = 0. No x values ever driven.
- 0x1A MULT, 0x1B MULTU: {y_hi, y_lo} = 2·WIDTH product. Shift-add, one bit per cycle, on magnitudes. Signed result negated in fixup.
- 0x1C DIV, 0x1D DIVU: restoring division, one bit per cycle; y_lo = quotient, y_hi = remainder. Signed: quotient truncates toward zero, remainder takes the sign of `s`.
- Divide by zero: y_lo = all ones, y_hi = s, V = 1. Takes the full latency.
- Mul/div flags: N = y_hi MSB, Z = ({y_hi, y_lo} == 0), C = 0, V = 0 except divide-by-zero.
- Signed DIV of most-negative by −1: y_lo = most-negative, y_hi = 0, V = 1.
- 0x0C–0x0E and 0x1E–0x1F: PASS_S behaviour, flags per PASS_S.
- FSM: IDLE → (start & single-cycle fs) IDLE with done; IDLE → (start & mul/div) CALC; CALC runs WIDTH cycles → FIX; FIX → IDLE with done.
- `start` while busy is ignored. Outputs hold their last result until the next done.

## Timing
- Start sampled at edge E.
- Single-cycle ops: results and done registered at E. Latency 1; done high during E..E+1. busy stays 0. Back-to-back starts accepted every cycle.
- Mul/div: busy = 1 from E; the CALC counter runs WIDTH cycles; FIX at edge E+WIDTH+1 registers results, asserts done and clears busy. Latency WIDTH+1. Next start accepted on the done cycle.
- reset_n low at any time, including mid-CALC: immediately returns to IDLE, all outputs 0, the partial result is discarded.

## Configuration
- `ALU_MULDIV_EN` defined: multiply/divide datapath, counter and CALC/FIX states are compiled in.
- Not defined: FS 0x1A–0x1D execute as single-cycle ZEROS with V = 1 (unsupported-op indication). busy is tied 0; the block is purely single-cycle registered.

## Structure
- Shared package `alu_pkg`:
  - FS opcode localparams `FS_PASS_S` … `FS_DIVU`.
  - FSM state enum `IDLE`, `CALC`, `FIX`.
  - Helper `is_multicycle(fs)`.
- Sub-module `alu_muldiv_core`:
  - Iterative unsigned shift-add/restoring engine with counter, `go`/`fin` strobes, and a mode input (mul/div).
  - The top handles sign conversion, fixup, the single-cycle ops and flags.
  - Omitted when `ALU_MULDIV_EN` is not defined.

## Test plan
- ADD s=7FFF_FFFF, t=1 → y_lo=8000_0000, N=1 V=1 C=0 Z=0, done one cycle after start, y_hi=0.
- SUB s=0, t=1 → y_lo=FFFF_FFFF, N=1 C=1 V=0; SUBU same operands → N=0 C=1 V=1.
- MULT s=FFFF_FFFE (−2), t=3 → y_hi=FFFF_FFFF, y_lo=FFFF_FFFA, N=1; done exactly 33 cycles after start; busy high throughout; a second start mid-op is ignored.
- DIV s=FFFF_FFF9 (−7), t=2 → y_lo=FFFF_FFFD, y_hi=FFFF_FFFF; DIVU 7/0 → y_lo=FFFF_FFFF, y_hi=7, V=1.
- Assert reset_n low 10 cycles into a MULTU → all outputs 0 immediately, busy 0. A subsequent ANDI s=FFFF_1234, t=00FF → y_lo=0000_0034.
- WIDTH=16 build, LUI t=00AB → y_lo=00AB; without `ALU_MULDIV_EN`, MULT → y_lo=0, V=1, busy never asserted.
